// File: rtl/ethernet_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_tx_arbiter
// Purpose  : Round-robin owner arbitration of one ethernet_sender write port,
//            with commit/drop/timeout release and non-owner violation flag.
// Revision : 1.0 - initial release
// ============================================================================
module ethernet_tx_arbiter #(
    parameter int num_req_p    = 4,
    parameter int buf_size_p   = 2048,
    parameter int send_width_p = 64,
    parameter int timeout_p    = 1024,
    localparam int c_size_w    = $clog2(buf_size_p) + 1,
    localparam int c_addr_w    = $clog2(buf_size_p)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_req_p-1:0]                     req_i,
    output logic [num_req_p-1:0]                     grant_o,
    output logic [num_req_p-1:0]                     ready_o,
    input  logic [num_req_p-1:0]                     packet_size_v_i,
    input  logic [num_req_p-1:0][c_size_w-1:0]       packet_size_i,
    input  logic [num_req_p-1:0][c_addr_w-1:0]       buffer_write_addr_i,
    input  logic [num_req_p-1:0][1:0]                buffer_write_op_size_i,
    input  logic [num_req_p-1:0][send_width_p-1:0]   buffer_write_data_i,
    input  logic [num_req_p-1:0]                     buffer_write_v_i,
    input  logic [num_req_p-1:0]                     send_i,
    input  logic                                     ready_i,
    output logic                                     packet_size_v_o,
    output logic [c_size_w-1:0]                      packet_size_o,
    output logic [c_addr_w-1:0]                      buffer_write_addr_o,
    output logic [1:0]                               buffer_write_op_size_o,
    output logic [send_width_p-1:0]                  buffer_write_data_o,
    output logic                                     buffer_write_v_o,
    output logic                                     send_o,
    output logic                                     violation_o,
    output logic [15:0]                              timeout_count_o
);

    localparam int c_idx_w = $clog2(num_req_p);
    localparam int c_cnt_w = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'((timeout_p > 0) ? timeout_p - 1 : 0);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(num_req_p - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_idx_w-1:0]     r_owner;
    logic [c_idx_w-1:0]     r_rr;
    logic [num_req_p-1:0]   r_grant;
    logic [c_cnt_w-1:0]     r_idle_cnt;
    logic                   r_violation;
    logic [15:0]            r_timeout_count;

    logic                   w_busy;
    logic                   w_own_sv;
    logic                   w_own_wv;
    logic                   w_own_sd;
    logic                   w_activity;
    logic                   w_rel_send;
    logic                   w_rel_drop;
    logic                   w_to_hit;
    logic                   w_release;
    logic                   w_timeout;
    logic                   w_arbitrate;
    logic [c_idx_w-1:0]     w_idx;
    logic [c_idx_w-1:0]     w_pick;
    logic                   w_pick_v;
    logic [num_req_p-1:0]   w_viol_mask;

    assign w_busy     = (r_state == ST_BUSY);
    assign w_own_sv   = packet_size_v_i[r_owner];
    assign w_own_wv   = buffer_write_v_i[r_owner];
    assign w_own_sd   = send_i[r_owner];
    assign w_activity = ready_i & (w_own_sv | w_own_wv | w_own_sd);

    // Release priority: commit, then request withdrawal, then idle timeout.
    assign w_rel_send = w_own_sd & ready_i;
    assign w_rel_drop = ~req_i[r_owner] & ~w_own_sd;
    assign w_to_hit   = (timeout_p != 0) && (r_idle_cnt == c_to_last) && !w_activity;
    assign w_release  = w_busy & (w_rel_send | w_rel_drop | w_to_hit);
    assign w_timeout  = w_busy & ~w_rel_send & ~w_rel_drop & w_to_hit;

    // Scan downward from the farthest offset so the nearest request at or after r_rr wins.
    always_comb begin
        w_pick   = '0;
        w_pick_v = 1'b0;
        w_idx    = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            w_idx = c_idx_w'((int'(r_rr) + k) % num_req_p);
            if (req_i[w_idx]) begin
                w_pick   = w_idx;
                w_pick_v = 1'b1;
            end
        end
    end

    assign w_arbitrate = ~w_busy & ready_i & w_pick_v;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_arbitrate) w_state_next = ST_BUSY;
            ST_BUSY: if (w_release)   w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    assign w_viol_mask = w_busy ? ~r_grant : {num_req_p{1'b1}};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_owner         <= '0;
            r_rr            <= '0;
            r_grant         <= '0;
            r_idle_cnt      <= '0;
            r_violation     <= 1'b0;
            r_timeout_count <= '0;
        end else begin
            r_violation <= |((packet_size_v_i | buffer_write_v_i | send_i) & w_viol_mask);
            if (w_arbitrate) begin
                r_owner    <= w_pick;
                r_grant    <= {{(num_req_p-1){1'b0}}, 1'b1} << w_pick;
                r_idle_cnt <= '0;
            end else if (w_release) begin
                r_grant <= '0;
                r_rr    <= (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;
                if (w_timeout && (r_timeout_count != 16'hFFFF))
                    r_timeout_count <= r_timeout_count + 16'd1;
            end else if (w_busy) begin
                r_idle_cnt <= w_activity ? '0 : r_idle_cnt + 1'b1;
            end
        end
    end

    assign grant_o                = r_grant;
    assign ready_o                = r_grant & {num_req_p{ready_i}};
    assign packet_size_v_o        = w_busy & w_own_sv & ready_i;
    assign buffer_write_v_o       = w_busy & w_own_wv & ready_i;
    assign send_o                 = w_busy & w_own_sd & ready_i;
    assign packet_size_o          = packet_size_i[r_owner];
    assign buffer_write_addr_o    = buffer_write_addr_i[r_owner];
    assign buffer_write_op_size_o = buffer_write_op_size_i[r_owner];
    assign buffer_write_data_o    = buffer_write_data_i[r_owner];
    assign violation_o            = r_violation;
    assign timeout_count_o        = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ethernet_tx_arbiter
// Purpose  : Table vectors, directed timeout sequence and randomized traffic
//            against a cycle-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ethernet_tx_arbiter;

    localparam int N  = 4;
    localparam int SW = 12;
    localparam int AW = 11;
    localparam int DW = 64;
    localparam int TO = 16;

    logic                     clk_i = 1'b0;
    logic                     reset_i;
    logic [N-1:0]             req_i;
    logic [N-1:0]             grant_o;
    logic [N-1:0]             ready_o;
    logic [N-1:0]             packet_size_v_i;
    logic [N-1:0][SW-1:0]     packet_size_i;
    logic [N-1:0][AW-1:0]     buffer_write_addr_i;
    logic [N-1:0][1:0]        buffer_write_op_size_i;
    logic [N-1:0][DW-1:0]     buffer_write_data_i;
    logic [N-1:0]             buffer_write_v_i;
    logic [N-1:0]             send_i;
    logic                     ready_i;
    logic                     packet_size_v_o;
    logic [SW-1:0]            packet_size_o;
    logic [AW-1:0]            buffer_write_addr_o;
    logic [1:0]               buffer_write_op_size_o;
    logic [DW-1:0]            buffer_write_data_o;
    logic                     buffer_write_v_o;
    logic                     send_o;
    logic                     violation_o;
    logic [15:0]              timeout_count_o;

    always #5 clk_i = ~clk_i;

    ethernet_tx_arbiter #(
        .num_req_p(N), .buf_size_p(2048), .send_width_p(DW), .timeout_p(TO)
    ) u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .grant_o(grant_o), .ready_o(ready_o),
        .packet_size_v_i(packet_size_v_i), .packet_size_i(packet_size_i),
        .buffer_write_addr_i(buffer_write_addr_i), .buffer_write_op_size_i(buffer_write_op_size_i),
        .buffer_write_data_i(buffer_write_data_i), .buffer_write_v_i(buffer_write_v_i),
        .send_i(send_i), .ready_i(ready_i),
        .packet_size_v_o(packet_size_v_o), .packet_size_o(packet_size_o),
        .buffer_write_addr_o(buffer_write_addr_o), .buffer_write_op_size_o(buffer_write_op_size_o),
        .buffer_write_data_o(buffer_write_data_o), .buffer_write_v_o(buffer_write_v_o),
        .send_o(send_o), .violation_o(violation_o), .timeout_count_o(timeout_count_o)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: who owns the port, where the rotation resumes, idle age.
    bit m_busy;
    int m_owner;
    int m_rr;
    int m_idle;
    int m_tocnt;
    bit m_viol;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        bit         rdy;
        logic [3:0] wv;
        logic [3:0] sd;
        logic [3:0] eg;
        bit         ewv;
        bit         esd;
        bit         eviol;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_rr    = 0;
        m_idle  = 0;
        m_tocnt = 0;
        m_viol  = 1'b0;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) begin
            packet_size_i[i]          = SW'($urandom);
            buffer_write_addr_i[i]    = AW'($urandom);
            buffer_write_op_size_i[i] = 2'($urandom);
            buffer_write_data_i[i]    = {$urandom, $urandom};
        end
    endtask

    task automatic model_check();
        logic [N-1:0] eg;
        eg = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        chk("grant", grant_o, eg);
        chk("ready_o", ready_o, eg & {N{ready_i}});
        chk("size_v", packet_size_v_o, m_busy && packet_size_v_i[m_owner] && ready_i);
        chk("write_v", buffer_write_v_o, m_busy && buffer_write_v_i[m_owner] && ready_i);
        chk("send", send_o, m_busy && send_i[m_owner] && ready_i);
        chk("violation", violation_o, m_viol);
        chk("timeouts", timeout_count_o, m_tocnt);
        if (m_busy) begin
            chk("size", packet_size_o, packet_size_i[m_owner]);
            chk("addr", buffer_write_addr_o, buffer_write_addr_i[m_owner]);
            chk("op_size", buffer_write_op_size_o, buffer_write_op_size_i[m_owner]);
            chk("data", buffer_write_data_o, buffer_write_data_i[m_owner]);
        end
    endtask

    task automatic model_step();
        bit nv;
        bit act;
        bit found;
        nv = 1'b0;
        for (int i = 0; i < N; i++)
            if ((packet_size_v_i[i] || buffer_write_v_i[i] || send_i[i]) && !(m_busy && i == m_owner))
                nv = 1'b1;
        if (reset_i) begin
            model_reset();
        end else begin
            m_viol = nv;
            if (!m_busy) begin
                if (ready_i && req_i != '0) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++)
                        if (!found && req_i[(m_rr + k) % N]) begin
                            found   = 1'b1;
                            m_owner = (m_rr + k) % N;
                        end
                    m_busy = 1'b1;
                    m_idle = 0;
                end
            end else begin
                act = ready_i && (packet_size_v_i[m_owner] || buffer_write_v_i[m_owner] || send_i[m_owner]);
                if ((send_i[m_owner] && ready_i) || (!req_i[m_owner] && !send_i[m_owner])) begin
                    m_busy = 1'b0;
                    m_rr   = (m_owner + 1) % N;
                end else if (!act && m_idle == TO - 1) begin
                    m_busy  = 1'b0;
                    m_rr    = (m_owner + 1) % N;
                    m_tocnt = (m_tocnt < 65535) ? m_tocnt + 1 : 65535;
                end else begin
                    m_idle = act ? 0 : m_idle + 1;
                end
            end
        end
    endtask

    task automatic mcycle();
        #3;
        model_check();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        int gcnt;

        //           rst req      rdy wv       sd       eg       ewv esd viol
        tbl[0]  = '{0, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[1]  = '{0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0};
        tbl[2]  = '{0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0};
        tbl[3]  = '{0, 4'b0001, 1, 4'b0000, 4'b0001, 4'b0001, 0, 1, 0};
        tbl[4]  = '{0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[5]  = '{0, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[6]  = '{0, 4'b0001, 1, 4'b0100, 4'b0000, 4'b0001, 0, 0, 0};
        tbl[7]  = '{0, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0001, 0, 0, 1};
        tbl[8]  = '{0, 4'b0001, 0, 4'b0000, 4'b0001, 4'b0001, 0, 0, 0};
        tbl[9]  = '{0, 4'b0001, 1, 4'b0000, 4'b0001, 4'b0001, 0, 1, 0};
        tbl[10] = '{0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[11] = '{0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[12] = '{0, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[13] = '{0, 4'b0010, 1, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0};
        tbl[14] = '{1, 4'b0010, 1, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0};
        tbl[15] = '{0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[16] = '{0, 4'b1111, 1, 4'b0000, 4'b0001, 4'b0001, 0, 1, 0};
        tbl[17] = '{0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[18] = '{0, 4'b1111, 1, 4'b0000, 4'b0010, 4'b0010, 0, 1, 0};
        tbl[19] = '{0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[20] = '{0, 4'b1111, 1, 4'b0000, 4'b0100, 4'b0100, 0, 1, 0};
        tbl[21] = '{0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[22] = '{0, 4'b1111, 1, 4'b0000, 4'b1000, 4'b1000, 0, 1, 0};
        tbl[23] = '{0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[24] = '{0, 4'b1111, 1, 4'b0000, 4'b0001, 4'b0001, 0, 1, 0};
        tbl[25] = '{0, 4'b0000, 1, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0};
        tbl[26] = '{0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1};

        reset_i          = 1'b1;
        req_i            = '0;
        ready_i          = 1'b1;
        packet_size_v_i  = '0;
        buffer_write_v_i = '0;
        send_i           = '0;
        randomize_data();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        #3;
        chk("reset grant", grant_o, 0);
        chk("reset ready_o", ready_o, 0);
        chk("reset send", send_o, 0);
        chk("reset violation", violation_o, 0);
        chk("reset timeouts", timeout_count_o, 0);
        @(posedge clk_i);
        #1;

        foreach (tbl[r]) begin
            reset_i          = tbl[r].rst;
            req_i            = tbl[r].req;
            ready_i          = tbl[r].rdy;
            buffer_write_v_i = tbl[r].wv;
            send_i           = tbl[r].sd;
            packet_size_v_i  = '0;
            randomize_data();
            #3;
            chk($sformatf("vec%0d grant", r), grant_o, tbl[r].eg);
            chk($sformatf("vec%0d ready_o", r), ready_o, tbl[r].eg & {N{tbl[r].rdy}});
            chk($sformatf("vec%0d write_v", r), buffer_write_v_o, tbl[r].ewv);
            chk($sformatf("vec%0d send", r), send_o, tbl[r].esd);
            chk($sformatf("vec%0d violation", r), violation_o, tbl[r].eviol);
            @(posedge clk_i);
            #1;
        end

        // Idle owner is revoked after TO cycles and rotation moves past it.
        reset_i = 1'b1;
        req_i = '0; packet_size_v_i = '0; buffer_write_v_i = '0; send_i = '0;
        @(posedge clk_i);
        #1;
        model_reset();
        reset_i = 1'b0;
        req_i   = 4'b0001;
        ready_i = 1'b1;
        gcnt    = 0;
        repeat (TO + 1) begin
            if (grant_o[0]) gcnt++;
            mcycle();
        end
        req_i = 4'b0011;
        #3;
        chk("timeout grant drop", grant_o, 4'b0000);
        chk("timeout count", timeout_count_o, 1);
        chk("timeout grant span", gcnt, TO);
        #1;
        mcycle();
        #3;
        chk("post-timeout owner", grant_o, 4'b0010);
        #1;
        mcycle();

        // Randomized traffic with occasional resets and ready stalls.
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            reset_i = ($urandom_range(0, 299) == 0);
            ready_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) req_i = N'($urandom);
            packet_size_v_i  = N'($urandom & $urandom & $urandom);
            buffer_write_v_i = N'($urandom & $urandom);
            send_i           = N'($urandom & $urandom & $urandom & $urandom);
            randomize_data();
            mcycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
